crossbar_arbiter: RTL and testbench

- Output-side arbiter and mux for one crossbar egress port; the counterpart of the per-destination crossbar points.
- Receives transmit requests from P_PORTS crossbar points and issues one-cycle round-robin grant pulses.
- Forwards the granted point's AXI-Stream packet to the egress port through a registered 2-entry skid stage.
- Re-arbitrates only after the packet's tlast handshake completes, or after a timeout abort.

---
 rtl/crossbar_pkg.sv | 19 +
 rtl/crossbar_arbiter_if.sv | 39 +++
 rtl/axis_skid_2.sv | 55 +++++
 rtl/crossbar_arbiter.sv | 132 +++++++++++++
 tb/tb_crossbar_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/crossbar_pkg.sv
// Shared constants and types for the crossbar egress arbiter and crossbar points.
package crossbar_pkg;
  localparam int unsigned P_DATA_W    = 64;
  localparam int unsigned P_KEEP_W    = 8;
  localparam int unsigned P_MAX_PORTS = 8;
  localparam int unsigned P_IDX_W     = 3;

  localparam logic [P_KEEP_W-1:0] P_KEEP_DFLT = 8'hff;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_WAIT_DATA,
    ST_FORWARD,
    ST_DRAIN
  } arb_state_e;

  typedef logic [P_IDX_W-1:0] port_idx_t;
endpackage

// File: rtl/crossbar_arbiter_if.sv
// Request/grant and AXI-Stream bundle between crossbar points, the egress arbiter and the egress port.
interface crossbar_arbiter_if #(
  parameter int unsigned P_PORTS = 8
);
  import crossbar_pkg::*;

  logic [P_PORTS-1:0]          i_trans_req;
  logic [P_PORTS-1:0]          o_trans_grant;
  logic [P_PORTS-1:0]          s_axis_tvalid;
  logic [P_DATA_W*P_PORTS-1:0] s_axis_tdata;
  logic [P_PORTS-1:0]          s_axis_tlast;
  logic [P_KEEP_W*P_PORTS-1:0] s_axis_tkeep;
  logic [P_PORTS-1:0]          s_axis_tuser;
  logic [P_PORTS-1:0]          s_axis_tready;
  logic                        m_axis_tvalid;
  logic [P_DATA_W-1:0]         m_axis_tdata;
  logic                        m_axis_tlast;
  logic [P_KEEP_W-1:0]         m_axis_tkeep;
  logic                        m_axis_tuser;
  logic                        m_axis_tready;
  logic                        o_timeout_err;
  logic                        o_busy;

  // Arbiter side
  modport master (
    input  i_trans_req, s_axis_tvalid, s_axis_tdata, s_axis_tlast, s_axis_tkeep, s_axis_tuser,
    input  m_axis_tready,
    output o_trans_grant, s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast,
    output m_axis_tkeep, m_axis_tuser, o_timeout_err, o_busy
  );

  // Crossbar points and egress sink side
  modport slave (
    output i_trans_req, s_axis_tvalid, s_axis_tdata, s_axis_tlast, s_axis_tkeep, s_axis_tuser,
    output m_axis_tready,
    input  o_trans_grant, s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast,
    input  m_axis_tkeep, m_axis_tuser, o_timeout_err, o_busy
  );
endinterface

// File: rtl/axis_skid_2.sv
// Two-entry registered stream slice: output register plus one overflow register.
module axis_skid_2 #(
  parameter int unsigned      P_W   = 73,
  parameter logic [P_W-1:0]   P_RST = '0
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           s_valid,
  input  logic [P_W-1:0] s_data,
  input  logic           s_last,
  output logic           o_full,
  output logic           o_busy,
  output logic           m_valid,
  output logic [P_W-1:0] m_data,
  output logic           m_last,
  input  logic           m_ready
);
  logic           sk_valid;
  logic [P_W-1:0] sk_data;
  logic           sk_last;
  logic           pop;

  assign pop    = m_valid & m_ready;
  assign o_full = sk_valid;
  assign o_busy = m_valid | sk_valid;

  // The overflow slot only fills while the output slot is held, so it drains first on pop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_valid  <= 1'b0;
      m_data   <= P_RST;
      m_last   <= 1'b0;
      sk_valid <= 1'b0;
      sk_data  <= P_RST;
      sk_last  <= 1'b0;
    end else if (!m_valid || pop) begin
      if (sk_valid) begin
        m_valid  <= 1'b1;
        m_data   <= sk_data;
        m_last   <= sk_last;
        sk_valid <= 1'b0;
      end else if (s_valid) begin
        m_valid <= 1'b1;
        m_data  <= s_data;
        m_last  <= s_last;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (s_valid) begin
      sk_valid <= 1'b1;
      sk_data  <= s_data;
      sk_last  <= s_last;
    end
  end
endmodule

// File: rtl/crossbar_arbiter.sv
// Egress-port arbiter: round-robin grant over crossbar points, forwards one packet per grant.
module crossbar_arbiter
  import crossbar_pkg::*;
#(
  parameter int unsigned P_PORTS   = 8,
  parameter logic [15:0] P_TIMEOUT = 16'd64
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  crossbar_arbiter_if.master   bus
);
  localparam int unsigned P_PAY_W = P_DATA_W + P_KEEP_W + 1;

  arb_state_e   state, state_nxt;
  port_idx_t    sel, sel_nxt, ptr, ptr_nxt;
  logic [15:0]  cnt, cnt_nxt;
  logic [P_PORTS-1:0] grant, tready;
  logic         timeout, push;
  logic         sk_full, sk_busy;
  logic         sel_valid, sel_last;
  logic [P_PAY_W-1:0] s_pay, m_pay;

  function automatic port_idx_t rr_pick(input logic [P_PORTS-1:0] req, input port_idx_t p);
    port_idx_t   pick;
    port_idx_t   idx;
    logic        found;
    int unsigned tmp;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < P_PORTS; i++) begin
      tmp = (32'(p) + i) % P_PORTS;
      idx = port_idx_t'(tmp);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign sel_valid = bus.s_axis_tvalid[sel];
  assign sel_last  = bus.s_axis_tlast[sel];
  assign s_pay     = {bus.s_axis_tuser[sel],
                      bus.s_axis_tkeep[32'(sel)*P_KEEP_W +: P_KEEP_W],
                      bus.s_axis_tdata[32'(sel)*P_DATA_W +: P_DATA_W]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
      sel   <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    grant     = '0;
    tready    = '0;
    timeout   = 1'b0;
    push      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.i_trans_req != '0) begin
          sel_nxt   = rr_pick(bus.i_trans_req, ptr);
          state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        grant[sel] = 1'b1;
        ptr_nxt    = (32'(sel) == P_PORTS - 1) ? '0 : sel + 1'b1;
        cnt_nxt    = '0;
        state_nxt  = ST_WAIT_DATA;
      end
      ST_WAIT_DATA: begin
        tready[sel] = !sk_full;
        if (sel_valid) begin
          push      = !sk_full;
          // A single-beat packet finishes here and goes straight to drain.
          state_nxt = (push && sel_last) ? ST_DRAIN : ST_FORWARD;
        end else if (cnt == P_TIMEOUT - 16'd1) begin
          timeout   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      ST_FORWARD: begin
        tready[sel] = !sk_full;
        push        = sel_valid && !sk_full;
        if (push && sel_last) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!sk_busy) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  axis_skid_2 #(
    .P_W   (P_PAY_W),
    .P_RST ({1'b0, P_KEEP_DFLT, {P_DATA_W{1'b0}}})
  ) u_skid (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .s_valid (push),
    .s_data  (s_pay),
    .s_last  (sel_last),
    .o_full  (sk_full),
    .o_busy  (sk_busy),
    .m_valid (bus.m_axis_tvalid),
    .m_data  (m_pay),
    .m_last  (bus.m_axis_tlast),
    .m_ready (bus.m_axis_tready)
  );

  assign bus.m_axis_tuser  = m_pay[P_PAY_W-1];
  assign bus.m_axis_tkeep  = m_pay[P_DATA_W +: P_KEEP_W];
  assign bus.m_axis_tdata  = m_pay[P_DATA_W-1:0];
  assign bus.o_trans_grant = grant;
  assign bus.s_axis_tready = tready;
  assign bus.o_timeout_err = timeout;
  assign bus.o_busy        = (state != ST_IDLE);
endmodule

// File: tb/tb_crossbar_arbiter.sv
// Scoreboard bench for crossbar_arbiter: driver predicts grants and egress beats, monitor checks them.
module tb_crossbar_arbiter;
  import crossbar_pkg::*;

  localparam int P   = 8;
  localparam int TMO = 64;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  logic clk, rst_n;
  crossbar_arbiter_if #(.P_PORTS(P)) bus();

  crossbar_arbiter #(.P_PORTS(P), .P_TIMEOUT(16'(TMO))) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int    tests = 0, fails = 0;
  beat_t eq[$];
  int    gq[$];
  int    toq[$];
  int    mptr = 0;
  int    cur_point = -1;
  int    rmode = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm, input string why);
    tests++;
    fails++;
    $display("FAIL %s: %s", nm, why);
  endtask

  // Reference round-robin: first requester at or after the pointer, else the lowest requester.
  task automatic predict(input logic [P-1:0] m, output int k);
    int cand[$];
    for (int i = 0; i < P; i++) if (m[i]) cand.push_back(i);
    k = cand[0];
    foreach (cand[j]) if (cand[j] >= mptr) begin k = cand[j]; break; end
    gq.push_back(k);
    mptr = (k + 1) % P;
  endtask

  // Egress sink readiness: 0 always, 1 pattern 1,0,0,1, 2 never, 3 random
  initial begin
    logic [3:0] pat;
    int pidx;
    pat = 4'b1001;
    pidx = 0;
    bus.m_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0: bus.m_axis_tready = 1'b1;
        1: begin bus.m_axis_tready = pat[pidx]; pidx = (pidx + 1) % 4; end
        2: bus.m_axis_tready = 1'b0;
        default: bus.m_axis_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  int          cyc = 0, grant_cyc = 0, occ = 0;
  bit          stall = 0;
  logic [74:0] snap;
  logic [P-1:0] emask, ge;
  int          e;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      occ   = 0;
      stall = 0;
    end else begin
      if (bus.o_trans_grant != '0) begin
        grant_cyc = cyc;
        if (gq.size() == 0) fail_now("grant", "unexpected grant pulse");
        else begin
          e = gq.pop_front();
          ge = '0;
          ge[e] = 1'b1;
          chk("grant", bus.o_trans_grant, ge);
        end
      end
      if (bus.o_timeout_err) begin
        if (toq.size() == 0) fail_now("timeout", "unexpected timeout pulse");
        else begin
          void'(toq.pop_front());
          chk("timeout_delay", cyc - grant_cyc, TMO);
        end
      end
      emask = '0;
      if (cur_point >= 0) emask[cur_point] = 1'b1;
      chk("tready_isolation", bus.s_axis_tready & ~emask, 0);
      if (occ >= 2) chk("tready_when_full", bus.s_axis_tready, 0);
      chk("m_valid_vs_occupancy", bus.m_axis_tvalid, occ != 0);
      if (stall)
        chk("stall_stable", {bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tkeep,
                             bus.m_axis_tlast, bus.m_axis_tuser}, snap);
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        if (eq.size() == 0) fail_now("egress_beat", "unexpected beat");
        else chk("egress_beat", {bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tlast,
                                 bus.m_axis_tuser}, eq.pop_front());
      end
      stall = bus.m_axis_tvalid && !bus.m_axis_tready;
      snap  = {bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tlast, bus.m_axis_tuser};
      occ   = occ + int'(|(bus.s_axis_tvalid & bus.s_axis_tready))
                  - int'(bus.m_axis_tvalid && bus.m_axis_tready);
    end
  end

  task automatic wait_grant();
    bit ok;
    ok = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (bus.o_trans_grant != '0) begin ok = 1; break; end
    end
    if (!ok) fail_now("wait_grant", "no grant within 100 cycles");
    @(posedge clk); #1;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 0;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (eq.size() == 0 && !bus.o_busy) begin ok = 1; break; end
    end
    if (!ok) fail_now("wait_drain", "egress not drained within 500 cycles");
    @(posedge clk); #1;
  endtask

  // Sends nsend beats of an n-beat packet from point k; push adds them to the scoreboard.
  task automatic send_pkt(input int k, input int n, input int nsend, input logic [7:0] last_keep,
                          input bit gaps, input bit push);
    beat_t b;
    bit ok;
    for (int i = 0; i < nsend; i++) begin
      b.data = {$urandom, $urandom};
      b.keep = (i == n - 1) ? last_keep : 8'($urandom);
      b.last = (i == n - 1);
      b.user = 1'($urandom);
      if (push) eq.push_back(b);
      if (gaps) begin
        bus.s_axis_tvalid[k] = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      bus.s_axis_tdata[64*k +: 64] = b.data;
      bus.s_axis_tkeep[8*k +: 8]   = b.keep;
      bus.s_axis_tlast[k]          = b.last;
      bus.s_axis_tuser[k]          = b.user;
      bus.s_axis_tvalid[k]         = 1'b1;
      ok = 0;
      for (int t = 0; t < 200; t++) begin
        @(negedge clk);
        if (bus.s_axis_tready[k]) begin ok = 1; break; end
      end
      @(posedge clk); #1;
      if (!ok) begin
        fail_now("s_ready", "beat not accepted within 200 cycles");
        break;
      end
    end
    bus.s_axis_tvalid[k] = 1'b0;
    bus.s_axis_tlast[k]  = 1'b0;
  endtask

  task automatic check_reset_vals();
    chk("rst_grant", bus.o_trans_grant, 0);
    chk("rst_tready", bus.s_axis_tready, 0);
    chk("rst_m_valid", bus.m_axis_tvalid, 0);
    chk("rst_m_data", bus.m_axis_tdata, 0);
    chk("rst_m_last", bus.m_axis_tlast, 0);
    chk("rst_m_keep", bus.m_axis_tkeep, 8'hff);
    chk("rst_m_user", bus.m_axis_tuser, 0);
    chk("rst_timeout", bus.o_timeout_err, 0);
    chk("rst_busy", bus.o_busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n;
    logic [P-1:0] m;
    rst_n             = 1'b0;
    bus.i_trans_req   = '0;
    bus.s_axis_tvalid = '0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tlast  = '0;
    bus.s_axis_tkeep  = '0;
    bus.s_axis_tuser  = '0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Single request from point 2, 4 beats, keep 0f on the last
    predict(8'h04, k);
    bus.i_trans_req = 8'h04;
    wait_grant();
    bus.i_trans_req = '0;
    chk("busy_after_grant", bus.o_busy, 1);
    cur_point = k;
    send_pkt(k, 4, 4, 8'h0f, 0, 1);
    cur_point = -1;
    wait_drain();
    chk("busy_after_drain", bus.o_busy, 0);

    // Isolation: point 1 holds tvalid while point 5 owns the port
    bus.s_axis_tdata[64*1 +: 64] = 64'hbad0_bad0_bad0_bad0;
    bus.s_axis_tvalid[1] = 1'b1;
    predict(8'h20, k);
    bus.i_trans_req = 8'h20;
    wait_grant();
    bus.i_trans_req = '0;
    cur_point = k;
    send_pkt(k, 3, 3, 8'hff, 1, 1);
    cur_point = -1;
    wait_drain();
    bus.s_axis_tvalid[1] = 1'b0;

    // Backpressure: 6-beat packet from point 7 with ready pattern 1,0,0,1
    rmode = 1;
    predict(8'h80, k);
    bus.i_trans_req = 8'h80;
    wait_grant();
    bus.i_trans_req = '0;
    cur_point = k;
    send_pkt(k, 6, 6, 8'h7f, 0, 1);
    cur_point = -1;
    wait_drain();
    rmode = 0;

    // Fairness: points 0 and 7 request continuously
    bus.i_trans_req = 8'h81;
    for (int r = 0; r < 4; r++) begin
      predict(8'h81, k);
      wait_grant();
      if (r == 3) bus.i_trans_req = '0;
      cur_point = k;
      send_pkt(k, 2, 2, 8'hff, 0, 1);
      cur_point = -1;
    end
    wait_drain();

    // Timeout: point 3 never sends, then point 4 sends a single beat
    predict(8'h08, k);
    toq.push_back(k);
    bus.i_trans_req = 8'h08;
    wait_grant();
    bus.i_trans_req = '0;
    cur_point = k;
    begin
      bit seen;
      seen = 0;
      for (int t = 0; t < TMO + 40; t++) begin
        @(negedge clk);
        if (bus.o_timeout_err) begin seen = 1; break; end
      end
      if (!seen) fail_now("timeout_wait", "no timeout pulse");
      @(posedge clk); #1;
    end
    cur_point = -1;
    chk("busy_after_timeout", bus.o_busy, 0);
    predict(8'h10, k);
    bus.i_trans_req = 8'h10;
    wait_grant();
    bus.i_trans_req = '0;
    cur_point = k;
    send_pkt(k, 1, 1, 8'h01, 0, 1);
    cur_point = -1;
    wait_drain();

    // Randomized traffic
    rmode = 3;
    for (int p = 0; p < 12; p++) begin
      m = P'($urandom_range(1, 255));
      predict(m, k);
      bus.i_trans_req = m;
      wait_grant();
      bus.i_trans_req = '0;
      cur_point = k;
      n = $urandom_range(1, 6);
      send_pkt(k, n, n, 8'($urandom), 1, 1);
      cur_point = -1;
      wait_drain();
    end
    rmode = 0;

    // Reset mid-packet: 2 of 5 beats buffered with egress stalled
    rmode = 2;
    predict(8'h01, k);
    bus.i_trans_req = 8'h01;
    wait_grant();
    bus.i_trans_req = '0;
    cur_point = k;
    send_pkt(k, 5, 2, 8'hff, 0, 0);
    rst_n = 1'b0;
    bus.s_axis_tvalid = '0;
    cur_point = -1;
    @(negedge clk);
    check_reset_vals();
    eq.delete();
    gq.delete();
    toq.delete();
    mptr = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rmode = 0;
    repeat (2) begin @(posedge clk); #1; end
    predict(8'h03, k);
    bus.i_trans_req = 8'h03;
    wait_grant();
    bus.i_trans_req = '0;
    cur_point = k;
    send_pkt(k, 3, 3, 8'h3f, 0, 1);
    cur_point = -1;
    wait_drain();

    repeat (5) @(negedge clk);
    chk("egress_queue_empty", eq.size(), 0);
    chk("grant_queue_empty", gq.size(), 0);
    chk("timeout_queue_empty", toq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
